falafel_req_arbiter: RTL and testbench
======================================

Name: falafel_req_arbiter

Overview:
- Round-robin arbiter and sequencer between NUM_REQ buffered request streams and the single allocator core.
- Each requester side is fed by a per-queue input buffer that has already tagged its entry with the queue ID.
- The block grants one requester, forwards its alloc_entry_t to the allocator, and waits for the allocator response.
- It routes that response back to the granted requester. Only one transaction is outstanding at a time.

Parameters:
- NUM_REQ, default 2: number of requesters; legal range 2..2**MSG_ID_SIZE.
- IDX_W, default $clog2(NUM_REQ): width of the grant index and round-robin pointer; derived, not overridden.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  reset, synchronous, active-low.
- req_val_i  input  NUM_REQ  per-requester valid.
- req_rdy_o  output  NUM_REQ  per-requester ready; one-hot or zero.
- req_data_i  input  NUM_REQ x alloc_entry_t  per-requester entry {id, data}.
- alloc_req_val_o  output  1  request valid to allocator.
- alloc_req_rdy_i  input  1  allocator ready.
- alloc_req_data_o  output  alloc_entry_t  latched granted entry.
- alloc_rsp_val_i  input  1  allocator response valid.
- alloc_rsp_rdy_o  output  1  arbiter ready for response.
- alloc_rsp_data_i  input  DATA_W  response payload.
- rsp_val_o  output  NUM_REQ  per-requester response valid; one-hot or zero.
- rsp_rdy_i  input  NUM_REQ  per-requester response ready.
- rsp_data_o  output  DATA_W  response payload, shared by all requesters.

Behaviour:
- Handshake rule: a transfer occurs on a cycle where val and rdy are both high. Valid must not depend combinationally on ready on any output side.
- FSM states and transitions:
  - IDLE -> ISSUE when any req_val_i is high.
  - ISSUE -> WAIT_RSP when alloc_req_rdy_i is high.
  - WAIT_RSP -> DELIVER when alloc_rsp_val_i is high.
  - DELIVER -> IDLE when rsp_rdy_i[owner] is high.
- Arbitration, IDLE only:
  - Winner is the first i with req_val_i[i] high, scanning from rr_ptr upward modulo NUM_REQ.
  - req_rdy_o[winner] is high combinationally in IDLE; all other bits are low. req_rdy_o is all zero outside IDLE.
  - On the grant: latch req_data_i[winner] into the entry register, set owner = winner, set rr_ptr = (winner+1) mod NUM_REQ.
- ISSUE:
  - alloc_req_val_o = 1 and alloc_req_data_o = entry register, held stable until accepted.
  - Latency is 1 cycle: a grant in cycle T gives alloc_req_val_o high in T+1.
- WAIT_RSP:
  - alloc_rsp_rdy_o = 1.
  - On acceptance, alloc_rsp_data_i is latched into the rsp_data register.
  - Responses arriving in any other state are not accepted (alloc_rsp_rdy_o = 0).
- DELIVER:
  - rsp_val_o[owner] = 1; rsp_data_o = rsp_data register, stable until rsp_rdy_i[owner].
  - rsp_rdy_i of non-owners is ignored.
  - Latency is 1 cycle: response accepted in cycle R gives rsp_val_o high in R+1.
- Turnaround: the next grant is possible in the cycle after DELIVER completes. Minimum per transaction is 4 cycles when all readies are constantly high.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0,... No requester waits more than NUM_REQ-1 other transactions.
- Simultaneous events:
  - A req_val_i that rises during ISSUE, WAIT_RSP or DELIVER is not granted until the next IDLE cycle.
  - A requester that drops valid before being granted loses nothing (its data stays in its own buffer).
- Reset (rst_ni low at a clock edge), including mid-transaction:
  - state = IDLE, rr_ptr = 0, owner = 0, entry and rsp_data registers = 0.
  - All val/rdy outputs = 0 during and after reset until the first IDLE grant.
  - An in-flight transaction is abandoned; no response is delivered for it.
- Constraints: the entry id field is passed through unmodified; the arbiter routes by the latched owner index, not by id.

Test Plan:
- Single requester: NUM_REQ=2, req 0 valid with {id=0, data=0x1234}, allocator ready always, response 0xBEEF after 3 cycles -> alloc_req_data_o={0,0x1234} one cycle after the grant; rsp_val_o=2'b01 with rsp_data_o=0xBEEF; rsp_val_o[1] never high.
- Round robin: both requesters continuously valid for 6 transactions, responses immediate -> grant order 0,1,0,1,0,1; each transaction takes 4 cycles.
- Backpressure: alloc_req_rdy_i low for 5 cycles in ISSUE, then rsp_rdy_i[1] low for 4 cycles in DELIVER -> alloc_req_val_o and alloc_req_data_o, and rsp_val_o[1] and rsp_data_o, held stable; req_rdy_o stays 0 throughout.
- Stray response: alloc_rsp_val_i pulsed in IDLE and in ISSUE -> alloc_rsp_rdy_o=0 and no rsp_val_o.
- Mid-operation reset: assert rst_ni=0 for 1 cycle during WAIT_RSP -> next cycle all outputs are 0 and state is IDLE; the next grant goes to requester 0 (rr_ptr=0).
- NUM_REQ=4, valid on 1 and 3 with rr_ptr=2 -> requester 3 is granted first, then requester 1.

Source files
------------

// File: rtl/falafel_req_arbiter.sv
// Round-robin arbiter that serialises NUM_REQ tagged request streams onto a
// single allocator core, one outstanding transaction at a time.
module falafel_req_arbiter #(
  parameter  int NUM_REQ     = 2,
  parameter  int MSG_ID_SIZE = 4,
  parameter  int DATA_W      = 16,
  localparam int IDX_W       = $clog2(NUM_REQ),
  localparam int ENTRY_W     = MSG_ID_SIZE + DATA_W
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_REQ-1:0]              req_val_i,
  output logic [NUM_REQ-1:0]              req_rdy_o,
  input  logic [NUM_REQ-1:0][ENTRY_W-1:0] req_data_i,
  output logic                            alloc_req_val_o,
  input  logic                            alloc_req_rdy_i,
  output logic [ENTRY_W-1:0]              alloc_req_data_o,
  input  logic                            alloc_rsp_val_i,
  output logic                            alloc_rsp_rdy_o,
  input  logic [DATA_W-1:0]               alloc_rsp_data_i,
  output logic [NUM_REQ-1:0]              rsp_val_o,
  input  logic [NUM_REQ-1:0]              rsp_rdy_i,
  output logic [DATA_W-1:0]               rsp_data_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DELIVER} state_t;

  state_t               state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     owner;
  logic [ENTRY_W-1:0]   entry_q;
  logic [DATA_W-1:0]    rsp_data_q;
  logic                 alloc_req_val_q;
  logic                 alloc_rsp_rdy_q;
  logic [NUM_REQ-1:0]   rsp_val_q;

  logic                 found;
  logic [IDX_W-1:0]     winner;
  logic [IDX_W-1:0]     cand;
  logic [IDX_W:0]       sum;
  logic [IDX_W-1:0]     next_ptr;

  // Scan upward from rr_ptr with wraparound; the first valid requester wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    sum    = '0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      cand = sum[IDX_W-1:0];
      if (!found && req_val_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign next_ptr = (winner == IDX_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;

  // Held low while reset is asserted so no grant is advertised mid-reset.
  always_comb begin
    req_rdy_o = '0;
    if (state == IDLE && rst_ni && found) req_rdy_o[winner] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      owner           <= '0;
      entry_q         <= '0;
      rsp_data_q      <= '0;
      alloc_req_val_q <= 1'b0;
      alloc_rsp_rdy_q <= 1'b0;
      rsp_val_q       <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          entry_q         <= req_data_i[winner];
          owner           <= winner;
          rr_ptr          <= next_ptr;
          alloc_req_val_q <= 1'b1;
          state           <= ISSUE;
        end
        ISSUE: if (alloc_req_rdy_i) begin
          alloc_req_val_q <= 1'b0;
          alloc_rsp_rdy_q <= 1'b1;
          state           <= WAIT_RSP;
        end
        WAIT_RSP: if (alloc_rsp_val_i) begin
          rsp_data_q      <= alloc_rsp_data_i;
          alloc_rsp_rdy_q <= 1'b0;
          rsp_val_q       <= NUM_REQ'(1) << owner;
          state           <= DELIVER;
        end
        DELIVER: if (rsp_rdy_i[owner]) begin
          rsp_val_q <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign alloc_req_val_o  = alloc_req_val_q;
  assign alloc_req_data_o = entry_q;
  assign alloc_rsp_rdy_o  = alloc_rsp_rdy_q;
  assign rsp_val_o        = rsp_val_q;
  assign rsp_data_o       = rsp_data_q;

endmodule

// File: tb/tb_falafel_req_arbiter.sv
// Bench for falafel_req_arbiter (NUM_REQ=4): directed scenarios plus random
// traffic, all checked every cycle against a transaction-level model.
module tb_falafel_req_arbiter;

  localparam int N   = 4;
  localparam int EW  = 20;
  localparam int DW  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_val;
  logic [N-1:0]      req_rdy;
  logic [N-1:0][EW-1:0] req_data;
  logic              alloc_req_val;
  logic              alloc_req_rdy;
  logic [EW-1:0]     alloc_req_data;
  logic              alloc_rsp_val;
  logic              alloc_rsp_rdy;
  logic [DW-1:0]     alloc_rsp_data;
  logic [N-1:0]      rsp_val;
  logic [N-1:0]      rsp_rdy;
  logic [DW-1:0]     rsp_data;

  int tests = 0;
  int fails = 0;
  int cycle = 0;

  always #5 clk = ~clk;

  falafel_req_arbiter #(.NUM_REQ(N), .MSG_ID_SIZE(4), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_val_i(req_val), .req_rdy_o(req_rdy), .req_data_i(req_data),
    .alloc_req_val_o(alloc_req_val), .alloc_req_rdy_i(alloc_req_rdy),
    .alloc_req_data_o(alloc_req_data),
    .alloc_rsp_val_i(alloc_rsp_val), .alloc_rsp_rdy_o(alloc_rsp_rdy),
    .alloc_rsp_data_i(alloc_rsp_data),
    .rsp_val_o(rsp_val), .rsp_rdy_i(rsp_rdy), .rsp_data_o(rsp_data)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h",
               name, cycle, actual, expected);
    end
  endtask

  // Model: one transaction at a time, walking request -> allocator -> response.
  // step 0 = free, 1 = entry offered to allocator, 2 = awaiting allocator
  // response, 3 = response offered to its owner.
  int            m_step, m_ptr, m_owner;
  logic [EW-1:0] m_entry;
  logic [DW-1:0] m_rsp;
  bit            model_ready = 1'b0;
  int            model_log[$];
  int            dut_log[$];
  int            dut_cyc[$];

  logic [N-1:0]  exp_rdy;
  int            win;
  int            c;

  always @(negedge clk) begin
    win = -1;
    if (model_ready) begin
      exp_rdy = '0;
      if (m_step == 0 && rst_n) begin
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (win < 0 && req_val[2'(c)]) win = c;
        end
        if (win >= 0) exp_rdy[2'(win)] = 1'b1;
      end
      checkOutput("req_rdy", 32'(req_rdy), 32'(exp_rdy));
      checkOutput("alloc_req_val", 32'(alloc_req_val), 32'(m_step == 1));
      checkOutput("alloc_req_data", 32'(alloc_req_data), 32'(m_entry));
      checkOutput("alloc_rsp_rdy", 32'(alloc_rsp_rdy), 32'(m_step == 2));
      checkOutput("rsp_val", 32'(rsp_val),
                  (m_step == 3) ? (32'd1 << m_owner) : 32'd0);
      checkOutput("rsp_data", 32'(rsp_data), 32'(m_rsp));
      if (win >= 0) model_log.push_back(win);
      for (int k = 0; k < N; k++)
        if (req_rdy[2'(k)] && req_val[2'(k)]) begin
          dut_log.push_back(k);
          dut_cyc.push_back(cycle);
        end
    end
    if (!rst_n) begin
      m_step = 0; m_ptr = 0; m_owner = 0; m_entry = '0; m_rsp = '0;
    end else begin
      case (m_step)
        0: if (win >= 0) begin
          m_entry = req_data[2'(win)];
          m_owner = win;
          m_ptr   = (win + 1) % N;
          m_step  = 1;
        end
        1: if (alloc_req_rdy) m_step = 2;
        2: if (alloc_rsp_val) begin
          m_rsp  = alloc_rsp_data;
          m_step = 3;
        end
        3: if (rsp_rdy[2'(m_owner)]) m_step = 0;
        default: m_step = 0;
      endcase
    end
    model_ready = 1'b1;
    cycle++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus();
    rst_n          = ($urandom_range(149) != 0);
    req_val        = N'($urandom);
    for (int k = 0; k < N; k++) req_data[k] = {4'(k), 16'($urandom)};
    alloc_req_rdy  = ($urandom_range(3) != 0);
    alloc_rsp_val  = ($urandom_range(2) == 0);
    alloc_rsp_data = 16'($urandom);
    rsp_rdy        = N'($urandom) | N'($urandom);
    tick();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic clearLogs();
    model_log.delete();
    dut_log.delete();
    dut_cyc.delete();
  endtask

  initial begin
    rst_n = 1'b0; req_val = '0; alloc_req_rdy = 1'b1; alloc_rsp_val = 1'b0;
    alloc_rsp_data = '0; rsp_rdy = '1;
    for (int k = 0; k < N; k++) req_data[k] = {4'(k), 16'h0};
    doReset();

    // Single requester, response three cycles into the wait.
    req_data[0] = {4'h0, 16'h1234};
    req_val = 4'b0001;
    tick();
    checkOutput("t1_alloc_val", 32'(alloc_req_val), 32'd1);
    checkOutput("t1_alloc_data", 32'(alloc_req_data), 32'h01234);
    req_val = '0;
    tick();
    tick();
    tick();
    alloc_rsp_val = 1'b1; alloc_rsp_data = 16'hBEEF;
    tick();
    alloc_rsp_val = 1'b0;
    checkOutput("t1_rsp_val", 32'(rsp_val), 32'b0001);
    checkOutput("t1_rsp_data", 32'(rsp_data), 32'hBEEF);
    tick();
    checkOutput("t1_rsp_done", 32'(rsp_val), 32'd0);

    // Round robin between requesters 0 and 1, everything always ready.
    doReset();
    clearLogs();
    req_val = 4'b0011; alloc_rsp_val = 1'b1; alloc_rsp_data = 16'h0042;
    for (int i = 0; i < 24; i++) tick();
    req_val = '0; alloc_rsp_val = 1'b0;
    checkOutput("t2_grant_count", 32'(dut_log.size()), 32'd6);
    checkOutput("t2_model_count", 32'(model_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < dut_log.size() && i < model_log.size(); i++) begin
      checkOutput("t2_grant_order", 32'(dut_log[i]), 32'(i % 2));
      checkOutput("t2_model_order", 32'(model_log[i]), 32'(i % 2));
      if (i > 0) checkOutput("t2_spacing", 32'(dut_cyc[i] - dut_cyc[i-1]), 32'd4);
    end

    // Backpressure on both the allocator request and the owner response.
    req_data[1] = {4'h1, 16'hCAFE};
    req_val = 4'b0010; alloc_req_rdy = 1'b0; rsp_rdy = '0;
    tick();
    req_val = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      checkOutput("t3_alloc_val", 32'(alloc_req_val), 32'd1);
      checkOutput("t3_alloc_data", 32'(alloc_req_data), 32'h1CAFE);
      checkOutput("t3_req_rdy", 32'(req_rdy), 32'd0);
      tick();
    end
    alloc_req_rdy = 1'b1;
    tick();
    alloc_rsp_val = 1'b1; alloc_rsp_data = 16'h5A5A;
    tick();
    alloc_rsp_val = 1'b0;
    rsp_rdy = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      checkOutput("t3_rsp_val", 32'(rsp_val), 32'b0010);
      checkOutput("t3_rsp_data", 32'(rsp_data), 32'h5A5A);
      checkOutput("t3_req_rdy_d", 32'(req_rdy), 32'd0);
      tick();
    end
    rsp_rdy = '1; req_val = '0;
    tick();

    // Stray allocator responses in IDLE and in ISSUE are refused.
    alloc_rsp_val = 1'b1; alloc_rsp_data = 16'hDEAD;
    tick();
    checkOutput("t4_idle_rsp_rdy", 32'(alloc_rsp_rdy), 32'd0);
    checkOutput("t4_idle_rsp_val", 32'(rsp_val), 32'd0);
    alloc_req_rdy = 1'b0; req_val = 4'b0001;
    tick();
    req_val = '0;
    tick();
    checkOutput("t4_issue_rsp_rdy", 32'(alloc_rsp_rdy), 32'd0);
    checkOutput("t4_issue_rsp_val", 32'(rsp_val), 32'd0);
    alloc_req_rdy = 1'b1;
    tick();
    tick();
    alloc_rsp_val = 1'b0;
    tick();

    // Reset while waiting on the allocator abandons the transaction.
    req_val = 4'b0100; alloc_rsp_val = 1'b0;
    tick();
    req_val = '0;
    tick();
    checkOutput("t5_in_wait", 32'(alloc_rsp_rdy), 32'd1);
    req_val = 4'b1111; rst_n = 1'b0;
    tick();
    checkOutput("t5_rst_req_rdy", 32'(req_rdy), 32'd0);
    checkOutput("t5_rst_alloc_val", 32'(alloc_req_val), 32'd0);
    checkOutput("t5_rst_rsp_rdy", 32'(alloc_rsp_rdy), 32'd0);
    checkOutput("t5_rst_rsp_val", 32'(rsp_val), 32'd0);
    checkOutput("t5_rst_entry", 32'(alloc_req_data), 32'd0);
    checkOutput("t5_rst_rsp_data", 32'(rsp_data), 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("t5_first_grant", 32'(req_rdy), 32'b0001);
    req_val = '0;
    tick();
    tick();
    alloc_rsp_val = 1'b1;
    tick();
    tick();
    alloc_rsp_val = 1'b0;

    // With the pointer at 2 and requesters 1 and 3 valid, 3 goes first.
    doReset();
    req_val = 4'b0010; alloc_rsp_val = 1'b1;
    tick();
    req_val = 4'b1010;
    clearLogs();
    for (int i = 0; i < 8; i++) tick();
    req_val = '0; alloc_rsp_val = 1'b0;
    checkOutput("t6_count", 32'(dut_log.size()), 32'd2);
    if (dut_log.size() >= 2) begin
      checkOutput("t6_first", 32'(dut_log[0]), 32'd3);
      checkOutput("t6_second", 32'(dut_log[1]), 32'd1);
    end
    tick();
    tick();

    // Random traffic, including occasional resets.
    for (int i = 0; i < 3000; i++) applyStimulus();
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
